// File: rtl/wbm_rr_arbiter.sv
// Round-robin arbiter sharing one WISHBONE host port among NUM_MASTERS masters, granting whole cyc cycles.
// Define WBM_RR_ARBITER_TIMEOUT_EN to add a stall watchdog that errors the owner after TIMEOUT_CYCLES.
module wbm_rr_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_MASTERS-1:0]               m_cyc_i,
  input  logic [NUM_MASTERS-1:0]               m_stb_i,
  input  logic [NUM_MASTERS-1:0]               m_we_i,
  input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]  m_sel_i,
  output logic [NUM_MASTERS-1:0]               m_ack_o,
  output logic [NUM_MASTERS-1:0]               m_err_o,
  output logic [NUM_MASTERS-1:0]               m_rty_o,
  output logic [DATA_WIDTH-1:0]                m_dat_o,
  output logic                                 wb_cyc_o,
  output logic                                 wb_stb_o,
  output logic                                 wb_we_o,
  output logic [ADDRESS_WIDTH-1:0]             wb_adr_o,
  output logic [DATA_WIDTH-1:0]                wb_dat_o,
  output logic [DATA_WIDTH/8-1:0]              wb_sel_o,
  input  logic [DATA_WIDTH-1:0]                wb_dat_i,
  input  logic                                 wb_ack_i,
  input  logic                                 wb_err_i,
  input  logic                                 wb_rty_i,
  output logic [NUM_MASTERS-1:0]               grant_o
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                   state, state_nxt;
  logic [IW-1:0]            owner, owner_nxt;
  logic [IW-1:0]            last_winner, last_winner_nxt;
  logic [IW-1:0]            pick;
  logic                     pick_vld;
  logic                     owned;
  logic                     timeout;
  logic                     own_cyc, own_stb, own_we;
  logic [ADDRESS_WIDTH-1:0] own_adr;
  logic [DATA_WIDTH-1:0]    own_dat;
  logic [SW-1:0]            own_sel;

  assign owned = (state == OWNED);

  // Rotating priority: scan upward from the slot after the last winner, wrapping.
  always_comb begin : rr_pick
    logic [IW-1:0] idx;
    pick_vld = 1'b0;
    pick     = last_winner;
    idx      = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = IW'((int'(last_winner) + i) % NUM_MASTERS);
      if (!pick_vld && m_cyc_i[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    grant_o = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (owner == IW'(k)) begin
        own_cyc    = m_cyc_i[k];
        own_stb    = m_stb_i[k];
        own_we     = m_we_i[k];
        own_adr    = m_adr_i[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        own_dat    = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
        own_sel    = m_sel_i[k*SW +: SW];
        grant_o[k] = owned;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    owner_nxt       = owner;
    last_winner_nxt = last_winner;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt       = OWNED;
          owner_nxt       = pick;
          last_winner_nxt = pick;
        end
      end
      OWNED: begin
        // Release only when the owner ends its cycle; newcomers wait for the idle cycle.
        if (!own_cyc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      owner       <= '0;
      last_winner <= IW'(NUM_MASTERS - 1);
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_winner <= last_winner_nxt;
    end
  end

`ifdef WBM_RR_ARBITER_TIMEOUT_EN
  localparam int TW = 16;
  logic [TW-1:0] to_cnt;

  assign timeout = owned && own_stb && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || !owned || wb_ack_i || wb_err_i || wb_rty_i || timeout) begin
      to_cnt <= '0;
    end else if (own_stb) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign wb_cyc_o = owned & own_cyc;
  assign wb_stb_o = owned & own_stb & ~timeout;
  assign wb_we_o  = owned & own_we;
  assign wb_adr_o = owned ? own_adr : '0;
  assign wb_dat_o = owned ? own_dat : '0;
  assign wb_sel_o = owned ? own_sel : '0;

  // grant_o is zero while idle, so terminations in IDLE are dropped here.
  assign m_ack_o = grant_o & {NUM_MASTERS{wb_ack_i}};
  assign m_err_o = grant_o & {NUM_MASTERS{wb_err_i | timeout}};
  assign m_rty_o = grant_o & {NUM_MASTERS{wb_rty_i}};
  assign m_dat_o = wb_dat_i;

endmodule

// File: tb/tb_wbm_rr_arbiter.sv
// Directed bench for wbm_rr_arbiter (NUM_MASTERS=4): cycle table plus hand-written corner sequences.
module tb_wbm_rr_arbiter;
  localparam int NM = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic           clk = 1'b0;
  logic           rst_i;
  logic [NM-1:0]  m_cyc_i, m_stb_i, m_we_i;
  logic [NM*AW-1:0] m_adr_i;
  logic [NM*DW-1:0] m_dat_i;
  logic [NM*SW-1:0] m_sel_i;
  logic [NM-1:0]  m_ack_o, m_err_o, m_rty_o;
  logic [DW-1:0]  m_dat_o;
  logic           wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0]  wb_adr_o;
  logic [DW-1:0]  wb_dat_o;
  logic [SW-1:0]  wb_sel_o;
  logic [DW-1:0]  wb_dat_i;
  logic           wb_ack_i, wb_err_i, wb_rty_i;
  logic [NM-1:0]  grant_o;

  int n_cmp = 0;
  int n_bad = 0;

  wbm_rr_arbiter #(
    .NUM_MASTERS(NM), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o), .m_dat_o(m_dat_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NM-1:0] cyc;
    logic [2:0]    term;   // {ack, err, rty}
    logic [NM-1:0] e_grant;
    logic          e_cyc;
    logic [AW-1:0] e_adr;
    logic [NM-1:0] e_ack, e_err, e_rty;
  } vec_t;

  vec_t vt[21];

  function automatic vec_t mkv(input logic [NM-1:0] cyc, input logic [2:0] term,
                               input logic [NM-1:0] g, input logic c, input logic [AW-1:0] adr,
                               input logic [NM-1:0] a, input logic [NM-1:0] e, input logic [NM-1:0] r);
    vec_t v;
    v.cyc = cyc; v.term = term; v.e_grant = g; v.e_cyc = c; v.e_adr = adr;
    v.e_ack = a; v.e_err = e; v.e_rty = r;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst_i = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    int acks;
    rst_i = 1'b1;
    clear_inputs();
    wb_dat_i = 32'hCAFE_0001;
    for (int k = 0; k < NM; k++) begin
      m_adr_i[k*AW +: AW] = AW'(16'h0100 + k);
      m_dat_i[k*DW +: DW] = DW'(32'h1000_0000 + k);
      m_sel_i[k*SW +: SW] = SW'(k + 1);
    end

    vt[0]  = mkv(4'b1111, 3'b000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000);
    vt[1]  = mkv(4'b1111, 3'b100, 4'b0001, 1'b1, 16'h0100, 4'b0001, 4'b0000, 4'b0000);
    vt[2]  = mkv(4'b1110, 3'b000, 4'b0001, 1'b0, 16'h0100, 4'b0000, 4'b0000, 4'b0000);
    vt[3]  = mkv(4'b1110, 3'b000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000);
    vt[4]  = mkv(4'b1110, 3'b100, 4'b0010, 1'b1, 16'h0101, 4'b0010, 4'b0000, 4'b0000);
    vt[5]  = mkv(4'b1100, 3'b000, 4'b0010, 1'b0, 16'h0101, 4'b0000, 4'b0000, 4'b0000);
    vt[6]  = mkv(4'b1100, 3'b000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000);
    vt[7]  = mkv(4'b1100, 3'b100, 4'b0100, 1'b1, 16'h0102, 4'b0100, 4'b0000, 4'b0000);
    vt[8]  = mkv(4'b1000, 3'b000, 4'b0100, 1'b0, 16'h0102, 4'b0000, 4'b0000, 4'b0000);
    vt[9]  = mkv(4'b1000, 3'b000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000);
    vt[10] = mkv(4'b1000, 3'b100, 4'b1000, 1'b1, 16'h0103, 4'b1000, 4'b0000, 4'b0000);
    vt[11] = mkv(4'b0001, 3'b000, 4'b1000, 1'b0, 16'h0103, 4'b0000, 4'b0000, 4'b0000);
    vt[12] = mkv(4'b0001, 3'b000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000);
    vt[13] = mkv(4'b0001, 3'b100, 4'b0001, 1'b1, 16'h0100, 4'b0001, 4'b0000, 4'b0000);
    vt[14] = mkv(4'b0000, 3'b000, 4'b0001, 1'b0, 16'h0100, 4'b0000, 4'b0000, 4'b0000);
    vt[15] = mkv(4'b0000, 3'b100, 4'b0000, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000);
    vt[16] = mkv(4'b0100, 3'b000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000);
    vt[17] = mkv(4'b0100, 3'b010, 4'b0100, 1'b1, 16'h0102, 4'b0000, 4'b0100, 4'b0000);
    vt[18] = mkv(4'b0100, 3'b001, 4'b0100, 1'b1, 16'h0102, 4'b0000, 4'b0000, 4'b0100);
    vt[19] = mkv(4'b0000, 3'b000, 4'b0100, 1'b0, 16'h0102, 4'b0000, 4'b0000, 4'b0000);
    vt[20] = mkv(4'b0000, 3'b000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000);

    // Reset state and a single write from master 0
    do_reset();
    chk("reset.grant", 32'(grant_o), 32'h0);
    chk("reset.wb_cyc", 32'(wb_cyc_o), 32'h0);
    m_adr_i[0 +: AW] = 16'h0010;
    m_dat_i[0 +: DW] = 32'hDEAD_BEEF;
    m_sel_i[0 +: SW] = 4'hF;
    m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_we_i[0] = 1'b1;
    #4;
    chk("wr.cyc_same_cycle", 32'(wb_cyc_o), 32'h0);
    tick();
    #4;
    chk("wr.cyc", 32'(wb_cyc_o), 32'h1);
    chk("wr.stb", 32'(wb_stb_o), 32'h1);
    chk("wr.we", 32'(wb_we_o), 32'h1);
    chk("wr.adr", 32'(wb_adr_o), 32'h0010);
    chk("wr.dat", wb_dat_o, 32'hDEAD_BEEF);
    chk("wr.sel", 32'(wb_sel_o), 32'hF);
    chk("wr.grant", 32'(grant_o), 32'h1);
    wb_ack_i = 1'b1;
    #1;
    chk("wr.ack", 32'(m_ack_o), 32'h1);
    chk("wr.m_dat", m_dat_o, 32'hCAFE_0001);
    tick();
    clear_inputs();
    m_adr_i[0 +: AW] = 16'h0100;
    m_dat_i[0 +: DW] = 32'h1000_0000;
    m_sel_i[0 +: SW] = 4'h1;

    // Round-robin cycle table
    do_reset();
    for (int i = 0; i < 21; i++) begin
      tick();
      m_cyc_i  = vt[i].cyc;
      m_stb_i  = vt[i].cyc;
      wb_ack_i = vt[i].term[2];
      wb_err_i = vt[i].term[1];
      wb_rty_i = vt[i].term[0];
      #4;
      chk($sformatf("v%0d.grant", i), 32'(grant_o), 32'(vt[i].e_grant));
      chk($sformatf("v%0d.wb_cyc", i), 32'(wb_cyc_o), 32'(vt[i].e_cyc));
      chk($sformatf("v%0d.wb_adr", i), 32'(wb_adr_o), 32'(vt[i].e_adr));
      chk($sformatf("v%0d.ack", i), 32'(m_ack_o), 32'(vt[i].e_ack));
      chk($sformatf("v%0d.err", i), 32'(m_err_o), 32'(vt[i].e_err));
      chk($sformatf("v%0d.rty", i), 32'(m_rty_o), 32'(vt[i].e_rty));
    end
    tick();
    clear_inputs();

    // Master 1 bursts four beats while master 2 waits
    do_reset();
    m_cyc_i = 4'b0110; m_stb_i = 4'b0110;
    tick();
    acks = 0;
    for (int b = 0; b < 4; b++) begin
      wb_ack_i = 1'b1;
      #4;
      chk($sformatf("burst%0d.grant", b), 32'(grant_o), 32'h2);
      if (m_ack_o == 4'b0010) acks++;
      tick();
    end
    chk("burst.acks_to_m1", 32'(acks), 32'd4);
    wb_ack_i = 1'b0;
    m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0;
    #4;
    chk("burst.release_grant", 32'(grant_o), 32'h2);
    tick();
    #4;
    chk("burst.idle_gap", 32'(grant_o), 32'h0);
    tick();
    #4;
    chk("burst.m2_granted", 32'(grant_o), 32'h4);
    tick();
    clear_inputs();

    // Reset mid-burst of master 3
    do_reset();
    m_cyc_i = 4'b1000; m_stb_i = 4'b1000;
    tick();
    #4;
    chk("rst3.grant_before", 32'(grant_o), 32'h8);
    tick();
    rst_i = 1'b1;
    tick();
    #4;
    chk("rst3.wb_cyc", 32'(wb_cyc_o), 32'h0);
    chk("rst3.grant", 32'(grant_o), 32'h0);
    rst_i = 1'b0;
    m_cyc_i = 4'b1001; m_stb_i = 4'b1001;
    tick();
    #4;
    chk("rst3.m0_first", 32'(grant_o), 32'h1);
    tick();
    clear_inputs();

    // Reset while master 1 owns: priority must restart at master 0
    do_reset();
    m_cyc_i = 4'b0010; m_stb_i = 4'b0010;
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    m_cyc_i = 4'b0101; m_stb_i = 4'b0101;
    tick();
    #4;
    chk("rst1.last_winner_reset", 32'(grant_o), 32'h1);
    tick();
    clear_inputs();

`ifdef WBM_RR_ARBITER_TIMEOUT_EN
    // Slave never terminates: watchdog fires on the 16th stalled cycle
    do_reset();
    m_cyc_i = 4'b0001; m_stb_i = 4'b0001;
    tick();
    for (int c = 1; c <= 16; c++) begin
      #4;
      if (c < 16) begin
        chk($sformatf("to%0d.err", c), 32'(m_err_o), 32'h0);
        chk($sformatf("to%0d.stb", c), 32'(wb_stb_o), 32'h1);
      end else begin
        chk("to16.err", 32'(m_err_o), 32'h1);
        chk("to16.stb", 32'(wb_stb_o), 32'h0);
        chk("to16.cyc", 32'(wb_cyc_o), 32'h1);
      end
      tick();
    end
    #4;
    chk("to17.err", 32'(m_err_o), 32'h0);
    chk("to17.stb", 32'(wb_stb_o), 32'h1);
    chk("to17.grant", 32'(grant_o), 32'h1);
    tick();
    clear_inputs();
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
